imem_fetch_queue: RTL and testbench

- Instruction-side responder to the PC generator.
- Each cycle it accepts the PC presented by the fetch stage and reads the instruction ROM, which has a one-cycle read latency.
- It buffers returned instructions, each tagged with its PC, in a small FIFO that the decode stage drains with a valid/ready handshake.
- It drives back Fetch_Stall (queue pressure) and Done (HALT retired), and drops in-flight and buffered words on a redirect (branch or exception).

---
 rtl/cpu_pkg.sv | 16 +
 rtl/imem_rom.sv | 24 ++
 rtl/imem_fetch_queue.sv | 128 ++++++++++++
 tb/tb_imem_fetch_queue.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-side types and constants for the instruction fetch path.
package cpu_pkg;

  localparam int PC_W    = 10;
  localparam int INSTR_W = 9;

  // Encoding that terminates the program once decode consumes it.
  localparam logic [INSTR_W-1:0] HALT_WORD = 9'h1FF;

  // One fetch-queue entry: the instruction word tagged with its address.
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/imem_rom.sv
// Synchronous-read instruction ROM. Contents are placed into mem by the
// environment; MEM_FILE names the intended image.
module imem_rom #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 9,
  parameter int DEPTH    = 1024,
  parameter     MEM_FILE = "machine_code.txt"
) (
  input  logic              clk_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] mem [DEPTH];

  // One-cycle read latency; the output register only moves on an enabled read.
  always_ff @(posedge clk_i) begin
    if (rd_en_i) begin
      data_o <= mem[addr_i];
    end
  end

endmodule

// File: rtl/imem_fetch_queue.sv
// Instruction fetch responder: reads the ROM at the PC offered each cycle,
// queues {pc, instr} entries for decode, reports queue pressure back to the
// PC generator, flushes on redirect and flags HALT retirement.
module imem_fetch_queue #(
  parameter int                    PC_W      = cpu_pkg::PC_W,
  parameter int                    INSTR_W   = cpu_pkg::INSTR_W,
  parameter int                    MEM_WORDS = 2 ** PC_W,
  parameter int                    QDEPTH    = 2,
  parameter logic [INSTR_W-1:0]    HALT_WORD = cpu_pkg::HALT_WORD,
  parameter                        MEM_FILE  = "machine_code.txt"
) (
  input  logic               CLK,
  input  logic               Init_n,
  input  logic [PC_W-1:0]    PC,
  input  logic               Redirect,
  input  logic               Instr_Ready,
  output logic               Fetch_Stall,
  output logic [INSTR_W-1:0] Instr,
  output logic [PC_W-1:0]    Instr_PC,
  output logic               Instr_Valid,
  output logic               Done
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = CNT_W + 1;

  // Read pipe: the word for rd_pc_q arrives from the ROM one cycle after issue.
  logic               rd_vld_q;
  logic [PC_W-1:0]    rd_pc_q;
  logic [INSTR_W-1:0] rd_data;

  // Queue state.
  cpu_pkg::fq_entry_t q_mem_q [QDEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q,  count_d;
  logic               done_q,   done_d;

  logic               issue, push, pop, pop_req, halt_pop;
  logic [OCC_W-1:0]   occ;
  cpu_pkg::fq_entry_t head, tail_entry;

  assign head        = q_mem_q[rd_ptr_q];
  assign Instr       = head.instr;
  assign Instr_PC    = head.pc;
  assign Instr_Valid = (count_q != '0);
  assign Done        = done_q;
  assign tail_entry  = '{pc: rd_pc_q, instr: rd_data};

  // Handshake decode: issue/push/pop qualifiers and the stall lookahead.
  always_comb begin
    pop_req  = Instr_Valid && Instr_Ready;
    // A redirect flushes the queue, so a coincident pop is void.
    pop      = pop_req && !Redirect;
    // Occupancy once the in-flight word lands, net of this cycle's pop; at
    // QDEPTH or more a new issue could push into a full queue.
    occ      = OCC_W'(count_q) + OCC_W'(rd_vld_q) - OCC_W'(pop_req);
    Fetch_Stall = done_q || (occ >= OCC_W'(QDEPTH));
    issue    = !Fetch_Stall && !Redirect;
    halt_pop = pop && (head.instr == HALT_WORD);
    done_d   = done_q || halt_pop;
    // Words younger than HALT are never executed, so the in-flight word is
    // dropped from the edge HALT retires onward.
    push     = rd_vld_q && !Redirect && !done_d;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (Redirect) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  imem_rom #(
    .ADDR_W   (PC_W),
    .DATA_W   (INSTR_W),
    .DEPTH    (MEM_WORDS),
    .MEM_FILE (MEM_FILE)
  ) u_rom (
    .clk_i   (CLK),
    .rd_en_i (issue),
    .addr_i  (PC),
    .data_o  (rd_data)
  );

  // Queue control and read-pipe valid; reset discards everything at once.
  always_ff @(posedge CLK or negedge Init_n) begin
    if (!Init_n) begin
      rd_vld_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      rd_vld_q <= issue;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      done_q   <= done_d;
    end
  end

  // PC tag for the word currently being read from the ROM.
  always_ff @(posedge CLK) begin
    if (issue) begin
      rd_pc_q <= PC;
    end
  end

  // Entry storage; cleared on reset so the head reads as zero until written.
  always_ff @(posedge CLK or negedge Init_n) begin
    if (!Init_n) begin
      for (int i = 0; i < QDEPTH; i++) begin
        q_mem_q[i] <= '0;
      end
    end else if (push) begin
      q_mem_q[wr_ptr_q] <= tail_entry;
    end
  end

endmodule

// File: tb/tb_imem_fetch_queue.sv
// Directed bench for imem_fetch_queue: the bench plays the PC generator and
// the decode stage, and checks each cycle against hand-derived values.
module tb_imem_fetch_queue;

  logic       CLK = 1'b0;
  logic       Init_n;
  logic [9:0] PC;
  logic       Redirect;
  logic       Instr_Ready;
  logic       Fetch_Stall;
  logic [8:0] Instr;
  logic [9:0] Instr_PC;
  logic       Instr_Valid;
  logic       Done;

  int n_chk = 0;
  int n_err = 0;

  imem_fetch_queue #(
    .MEM_FILE ("")
  ) dut (
    .CLK         (CLK),
    .Init_n      (Init_n),
    .PC          (PC),
    .Redirect    (Redirect),
    .Instr_Ready (Instr_Ready),
    .Fetch_Stall (Fetch_Stall),
    .Instr       (Instr),
    .Instr_PC    (Instr_PC),
    .Instr_Valid (Instr_Valid),
    .Done        (Done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock edge; the PC generator advances only if the DUT could take it.
  task automatic step();
    logic adv;
    adv = !Fetch_Stall && !Redirect;
    @(posedge CLK);
    #1;
    if (adv) PC = PC + 10'd1;
  endtask

  task automatic check_head(input string tag, input logic [9:0] pc, input logic [8:0] ins);
    chk({tag, "_valid"}, 32'(Instr_Valid), 32'd1);
    chk({tag, "_pc"},    32'(Instr_PC),    32'(pc));
    chk({tag, "_instr"}, 32'(Instr),       32'(ins));
  endtask

  // Holds reset across one edge, then releases it just after an edge.
  task automatic reset_cycle();
    Init_n      = 1'b0;
    Redirect    = 1'b0;
    Instr_Ready = 1'b1;
    PC          = 10'd0;
    @(posedge CLK);
    #1;
    Init_n = 1'b1;
  endtask

  // From reset release with Instr_Ready=1: valid from edge 2, one per cycle.
  task automatic free_run(input string tag);
    step();
    chk({tag, "_e1_valid"}, 32'(Instr_Valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_head($sformatf("%s_e%0d", tag, i + 2), 10'(i), 9'(i + 1));
      chk($sformatf("%s_e%0d_stall", tag, i + 2), 32'(Fetch_Stall), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) dut.u_rom.mem[i] = 9'h000;
    for (int i = 0; i < 5; i++) dut.u_rom.mem[i] = 9'(i + 1);
    dut.u_rom.mem[5]   = 9'h1FF;
    dut.u_rom.mem[6]   = 9'h007;
    dut.u_rom.mem[7]   = 9'h008;
    dut.u_rom.mem[288] = 9'h0A5;
    dut.u_rom.mem[289] = 9'h0A6;

    // Reset values, then free-run.
    Init_n      = 1'b0;
    Redirect    = 1'b0;
    Instr_Ready = 1'b1;
    PC          = 10'd0;
    @(posedge CLK);
    #1;
    chk("rst_valid", 32'(Instr_Valid), 32'd0);
    chk("rst_instr", 32'(Instr),       32'd0);
    chk("rst_pc",    32'(Instr_PC),    32'd0);
    chk("rst_stall", 32'(Fetch_Stall), 32'd0);
    chk("rst_done",  32'(Done),        32'd0);
    Init_n = 1'b1;
    free_run("run1");

    // Backpressure from edge 3.
    reset_cycle();
    step();
    step();
    Instr_Ready = 1'b0;
    #1;
    chk("bp_stall_e2", 32'(Fetch_Stall), 32'd1);
    for (int e = 3; e <= 5; e++) begin
      step();
      check_head($sformatf("bp_e%0d", e), 10'd0, 9'h001);
      chk($sformatf("bp_e%0d_stall", e), 32'(Fetch_Stall), 32'd1);
    end
    Instr_Ready = 1'b1;
    #1;
    chk("bp_release_stall", 32'(Fetch_Stall), 32'd0);
    step();
    check_head("bp_e6", 10'd1, 9'h002);
    step();
    check_head("bp_e7", 10'd2, 9'h003);

    // Redirect while the queue is full.
    Instr_Ready = 1'b0;
    #1;
    chk("rf_stall_pre", 32'(Fetch_Stall), 32'd1);
    step();
    check_head("rf_full", 10'd2, 9'h003);
    Redirect = 1'b1;
    step();
    Redirect    = 1'b0;
    PC          = 10'd288;
    Instr_Ready = 1'b1;
    #1;
    chk("rf_flush_valid", 32'(Instr_Valid), 32'd0);
    chk("rf_flush_stall", 32'(Fetch_Stall), 32'd0);
    step();
    chk("rf_issue_valid", 32'(Instr_Valid), 32'd0);
    step();
    check_head("rf_new0", 10'd288, 9'h0A5);
    step();
    check_head("rf_new1", 10'd289, 9'h0A6);

    // Redirect together with a pop, then run into HALT.
    Redirect = 1'b1;
    step();
    Redirect = 1'b0;
    PC       = 10'd4;
    #1;
    chk("rp_flush_valid", 32'(Instr_Valid), 32'd0);
    chk("rp_flush_stall", 32'(Fetch_Stall), 32'd0);
    step();
    chk("rp_issue_valid", 32'(Instr_Valid), 32'd0);
    step();
    check_head("rp_pc4", 10'd4, 9'h005);
    step();
    check_head("halt_head", 10'd5, 9'h1FF);
    chk("halt_done_pre", 32'(Done), 32'd0);
    step();
    chk("halt_done",  32'(Done),        32'd1);
    chk("halt_valid", 32'(Instr_Valid), 32'd0);
    chk("halt_stall", 32'(Fetch_Stall), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("halt_after%0d_valid", i), 32'(Instr_Valid), 32'd0);
      chk($sformatf("halt_after%0d_done", i),  32'(Done),        32'd1);
      chk($sformatf("halt_after%0d_stall", i), 32'(Fetch_Stall), 32'd1);
    end

    // Asynchronous reset clears Done without a clock edge.
    #2;
    Init_n = 1'b0;
    #1;
    chk("arst_done",  32'(Done),        32'd0);
    chk("arst_stall", 32'(Fetch_Stall), 32'd0);

    // Fill to two entries, then reset between edges.
    @(posedge CLK);
    #1;
    Init_n      = 1'b1;
    PC          = 10'd0;
    Instr_Ready = 1'b0;
    step();
    step();
    step();
    check_head("arst_full", 10'd0, 9'h001);
    chk("arst_full_stall", 32'(Fetch_Stall), 32'd1);
    #2;
    Init_n = 1'b0;
    #1;
    chk("arst2_valid", 32'(Instr_Valid), 32'd0);
    chk("arst2_stall", 32'(Fetch_Stall), 32'd0);
    chk("arst2_done",  32'(Done),        32'd0);
    chk("arst2_instr", 32'(Instr),       32'd0);
    chk("arst2_pc",    32'(Instr_PC),    32'd0);
    @(posedge CLK);
    #1;
    PC          = 10'd0;
    Instr_Ready = 1'b1;
    Redirect    = 1'b0;
    Init_n      = 1'b1;
    free_run("run2");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
